// File: rtl/riscv_muldiv.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Define RISCV_MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier.
module riscv_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    input  logic             flush_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic             busy_o
);

    localparam int W  = WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [2*W-1:0] acc_q;
    logic [W-1:0]   opnd_q;
    logic [CW-1:0]  cnt_q;
    logic [2:0]     op_q;
    logic           neg_q;

    logic           accept;
    logic           a_sgn;
    logic           b_sgn;
    logic [W-1:0]   mag_a;
    logic [W-1:0]   mag_b;
    logic           in_neg;
    logic           div_zero;
    logic           div_ovf;
    logic           special;
    logic [W-1:0]   special_res;
    logic           fast_mul;
    logic [W-1:0]   fast_res;

    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_nx;
    logic [W:0]     div_sh;
    logic [W:0]     div_diff;
    logic           div_ge;
    logic [2*W-1:0] div_nx;
    logic [2*W-1:0] acc_nx;
    logic [2*W-1:0] prod_s;
    logic [W-1:0]   quo;
    logic [W-1:0]   rem;
    logic [W-1:0]   mul_res;
    logic [W-1:0]   div_res;
    logic [W-1:0]   fin_res;
    logic           last_iter;
    logic           unused_ok;

    assign accept = valid_i && (state_q == IDLE) && !flush_i;

    // Which operands are treated as two's complement for each funct3
    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        unique case (op_i)
            3'd1: begin
                a_sgn = opa_i[W-1];
                b_sgn = opb_i[W-1];
            end
            3'd2: a_sgn = opa_i[W-1];
            3'd4, 3'd6: begin
                a_sgn = opa_i[W-1];
                b_sgn = opb_i[W-1];
            end
            default: ;
        endcase
    end

    assign mag_a = a_sgn ? (~opa_i + 1'b1) : opa_i;
    assign mag_b = b_sgn ? (~opb_i + 1'b1) : opb_i;
    // REM follows the dividend; everything else follows sign(a)^sign(b)
    assign in_neg = (op_i[2] && op_i[1]) ? a_sgn : (a_sgn ^ b_sgn);

    assign div_zero = op_i[2] && (opb_i == '0);
    assign div_ovf  = op_i[2] && !op_i[0] && (opa_i == SMIN) && (&opb_i);
    assign special  = div_zero || div_ovf;

    always_comb begin
        special_res = '0;
        unique case (1'b1)
            div_zero: special_res = op_i[1] ? opa_i : '1;
            div_ovf:  special_res = op_i[1] ? '0 : SMIN;
            default:  special_res = '0;
        endcase
    end

`ifdef RISCV_MULDIV_FAST_MUL_EN
    logic [2*W-1:0] fprod;
    logic [2*W-1:0] fprod_s;
    assign fprod    = {{W{1'b0}}, mag_a} * {{W{1'b0}}, mag_b};
    assign fprod_s  = in_neg ? (~fprod + 1'b1) : fprod;
    assign fast_res = (op_i[1:0] == 2'd0) ? fprod_s[W-1:0] : fprod_s[2*W-1:W];
    assign fast_mul = !op_i[2];
`else
    assign fast_res = '0;
    assign fast_mul = 1'b0;
`endif

    // Shift-add: multiplier sits in the low half and shifts out LSB first
    assign mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_nx  = {mul_sum, acc_q[W-1:1]};

    // Restoring divide: high half is the partial remainder, low half the quotient
    assign div_sh   = acc_q[2*W-1:W-1];
    assign div_ge   = (div_sh >= {1'b0, opnd_q});
    assign div_diff = div_sh - {1'b0, opnd_q};
    assign div_nx   = {(div_ge ? div_diff[W-1:0] : div_sh[W-1:0]),
                       acc_q[W-2:0], div_ge};
    assign unused_ok = div_diff[W];

    assign acc_nx = (state_q == DIV) ? div_nx : mul_nx;

    assign prod_s  = neg_q ? (~acc_nx + 1'b1) : acc_nx;
    assign mul_res = (op_q[1:0] == 2'd0) ? prod_s[W-1:0] : prod_s[2*W-1:W];
    assign quo     = acc_nx[W-1:0];
    assign rem     = acc_nx[2*W-1:W];
    always_comb begin
        div_res = '0;
        unique case (1'b1)
            op_q[1]:  div_res = neg_q ? (~rem + 1'b1) : rem;
            default:  div_res = neg_q ? (~quo + 1'b1) : quo;
        endcase
    end
    assign fin_res   = op_q[2] ? div_res : mul_res;
    assign last_iter = (state_q == MUL || state_q == DIV) && (cnt_q == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (special || fast_mul) begin
                        state_d = DONE;
                    end else if (op_i[2]) begin
                        state_d = DIV;
                    end else begin
                        state_d = MUL;
                    end
                end
            end
            MUL, DIV: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        ready_o = (state_q == IDLE);
        busy_o  = (state_q == MUL) || (state_q == DIV);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q    <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            valid_o  <= 1'b0;
            result_o <= '0;
        end else begin
            valid_o <= (state_d == DONE);
            if (accept) begin
                op_q   <= op_i;
                neg_q  <= in_neg;
                cnt_q  <= CW'(W - 1);
                acc_q  <= op_i[2] ? {{W{1'b0}}, mag_a} : {{W{1'b0}}, mag_b};
                opnd_q <= op_i[2] ? mag_b : mag_a;
                if (special) begin
                    result_o <= special_res;
                end else if (fast_mul) begin
                    result_o <= fast_res;
                end
            end else if (busy_o && !flush_i) begin
                acc_q <= acc_nx;
                cnt_q <= cnt_q - CW'(1);
                if (last_iter) begin
                    result_o <= fin_res;
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_muldiv.sv
// Directed and random checks of riscv_muldiv at WIDTH=32.
// Expected values are hand-computed or come from a behavioural model.
module tb_riscv_muldiv;

    localparam logic [31:0] MIN = 32'h8000_0000;
`ifdef RISCV_MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [2:0]  op_i;
    logic [31:0] opa_i;
    logic [31:0] opb_i;
    logic        flush_i;
    logic        valid_o;
    logic [31:0] result_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    riscv_muldiv #(.WIDTH(32)) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .op_i     (op_i),
        .opa_i    (opa_i),
        .opb_i    (opb_i),
        .flush_i  (flush_i),
        .valid_o  (valid_o),
        .result_o (result_o),
        .busy_o   (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * $signed(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN && b == 32'hFFFF_FFFF) return MIN;
                return $signed(a) / $signed(b);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN && b == 32'hFFFF_FFFF) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Called at a negedge; returns #1 after the accept edge (cycle 1)
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input string tag);
        int n;
        n = 0;
        while (!ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) chk({tag, " ready"}, {63'b0, ready_o}, 64'd1);
        valid_i = 1'b1;
        op_i    = op;
        opa_i   = a;
        opb_i   = b;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        opa_i   = $urandom;
        opb_i   = $urandom;
    endtask

    task automatic finish_op(input logic [31:0] exp, input int lat,
                             input string tag);
        int seen_at;
        int busy_n;
        seen_at = -1;
        busy_n  = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (busy_o) busy_n++;
            if (valid_o) begin
                seen_at = c;
                break;
            end
        end
        chk({tag, " latency"}, 64'(seen_at), 64'(lat));
        chk({tag, " result"}, {32'b0, result_o}, {32'b0, exp});
        chk({tag, " busy"}, 64'(busy_n), 64'(lat - 1));
        @(negedge clk);
        chk({tag, " pulse/ready"}, {62'b0, valid_o, ready_o}, 64'd1);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input int lat, input string tag);
        issue(op, a, b, tag);
        finish_op(exp, lat, tag);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        spec;
        int          vcount;
        rst_i   = 1'b1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        op_i    = 3'd0;
        opa_i   = '0;
        opb_i   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("reset", {60'b0, ready_o, valid_o, busy_o, 1'b0}, 64'b1000);
        chk("reset result", {32'b0, result_o}, 64'd0);

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, "mul");
        run_op(3'd1, MIN, MIN, 32'h4000_0000, MUL_LAT, "mulh");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, "mulhu");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, "mulhsu");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT, "div");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT, "rem");
        run_op(3'd5, 32'd100, 32'd7, 32'd14, DIV_LAT, "divu");
        run_op(3'd7, 32'd100, 32'd7, 32'd2, DIV_LAT, "remu");
        run_op(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div0");
        run_op(3'd7, 32'd5, 32'd0, 32'd5, 1, "remu0");

        // Abort a DIV in cycle 10: no completion, result register untouched
        issue(3'd4, 32'd100, 32'd7, "flush");
        vcount = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (valid_o) vcount++;
            if (c == 10) flush_i = 1'b1;
        end
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        @(negedge clk);
        chk("flush ready", {62'b0, ready_o, valid_o}, 64'b10);
        chk("flush result", {32'b0, result_o}, 64'd5);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (valid_o) vcount++;
        end
        chk("flush no valid", 64'(vcount), 64'd0);
        run_op(3'd5, 32'd9, 32'd3, 32'd3, DIV_LAT, "divu after flush");

        run_op(3'd4, MIN, 32'hFFFF_FFFF, MIN, 1, "div ovf");
        run_op(3'd6, MIN, 32'hFFFF_FFFF, 32'd0, 1, "rem ovf");
        run_op(3'd0, 32'd6, 32'd7, 32'd42, MUL_LAT, "mul pre-reset");

        issue(3'd0, 32'd3, 32'd5, "reset mid-mul");
        repeat (5) @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("reset mid-mul flags", {61'b0, ready_o, valid_o, busy_o}, 64'b100);
        chk("reset mid-mul result", {32'b0, result_o}, 64'd0);
        vcount = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (valid_o) vcount++;
        end
        chk("reset mid-mul no valid", 64'(vcount), 64'd0);

        for (int i = 0; i < 50; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = MIN; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            spec = rop[2] && ((rb == 0) ||
                   (!rop[0] && ra == MIN && rb == 32'hFFFF_FFFF));
            run_op(rop, ra, rb, model(rop, ra, rb),
                   spec ? 1 : (rop[2] ? DIV_LAT : MUL_LAT),
                   $sformatf("rand%0d op%0d", i, rop));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
